// File: rtl/inst_fetch_if.sv
// Bus between the fetch stage, the instruction ROM and the decode stage.
// The master modport is the fetch stage side.
`timescale 1ns/1ps
interface inst_fetch_if #(
    parameter int PC_W   = 32,
    parameter int ROM_AW = 16
);
    logic              stall_i;
    logic              redirect_i;
    logic [PC_W-1:0]   redirect_pc_i;
    logic              rom_en_o;
    logic [ROM_AW-1:0] rom_addr_o;
    logic [31:0]       rom_data_i;
    logic [31:0]       inst_o;
    logic [PC_W-1:0]   inst_pc_o;
    logic              inst_valid_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, rom_data_i,
        output rom_en_o, rom_addr_o, inst_o, inst_pc_o, inst_valid_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, rom_data_i,
        input  rom_en_o, rom_addr_o, inst_o, inst_pc_o, inst_valid_o
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency ROM and pairs
// each returned word with its PC, with a stall hold buffer and zero-bubble redirect.
`timescale 1ns/1ps
module inst_fetch #(
    parameter int              PC_W     = 32,
    parameter int              ROM_AW   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        reset,
    inst_fetch_if.master bus
);
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_out_pc;
    logic            r_out_valid;
    logic [31:0]     r_hold;
    logic            r_hold_sel;

    logic [PC_W-1:0] w_tgt;
    logic            w_fire;
    logic [PC_W-1:0] w_issue_pc;

    assign w_tgt      = bus.redirect_pc_i & ~PC_W'(3);
    assign w_fire     = ~bus.stall_i | bus.redirect_i;
    assign w_issue_pc = bus.redirect_i ? w_tgt : r_pc;

    // While in reset the ROM keeps reading the reset vector, independent of stall/redirect.
    assign bus.rom_en_o   = ~reset | w_fire;
    assign bus.rom_addr_o = reset ? w_issue_pc[ROM_AW+1:2] : RESET_PC[ROM_AW+1:2];

    assign bus.inst_o       = r_hold_sel ? r_hold : bus.rom_data_i;
    assign bus.inst_pc_o    = r_out_pc;
    assign bus.inst_valid_o = r_out_valid & ~bus.redirect_i;

    // On the first stalled edge the ROM word is captured, so the ROM may change underneath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= RESET_PC;
            r_out_pc    <= '0;
            r_out_valid <= 1'b0;
            r_hold      <= '0;
            r_hold_sel  <= 1'b0;
        end else if (w_fire) begin
            r_pc        <= w_issue_pc + PC_W'(4);
            r_out_pc    <= w_issue_pc;
            r_out_valid <= 1'b1;
            r_hold_sel  <= 1'b0;
        end else if (!r_hold_sel) begin
            r_hold      <= bus.rom_data_i;
            r_hold_sel  <= 1'b1;
        end
    end
endmodule
